// File: rtl/seg_execute_pkg.sv
// Shared definitions for the execute-stage multiply/divide slice:
// op encodings, control states and the forwarding-select width helper.
package seg_execute_pkg;

  typedef enum logic [2:0] {
    OP_ALU   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MFHI  = 3'b101,
    OP_MFLO  = 3'b110,
    OP_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Width of a forwarding select able to name "no forward" plus every source.
  function automatic int nb_sel(input int n_fwd);
    return $clog2(n_fwd + 1);
  endfunction

  // True for the ops that occupy the iterative unit.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/seg_execute_md_core.sv
// Iterative shift-add multiplier and restoring divider working on operand
// magnitudes, with sign correction applied to the final step's result.
module seg_execute_md_core
  import seg_execute_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [2:0]     i_op,
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  output logic           o_done,
  output logic [LEN-1:0] o_hi,
  output logic [LEN-1:0] o_lo
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*LEN-1:0] p_q, p_d;
  logic [LEN-1:0]   b_q, b_d;
  logic [LEN-1:0]   a_q, a_d;
  logic             is_div_q, is_div_d;
  logic             neg_main_q, neg_main_d;
  logic             neg_rem_q, neg_rem_d;
  logic             b_zero_q, b_zero_d;

  logic             signed_op, div_op, a_neg, b_neg;
  logic [LEN-1:0]   a_mag, b_mag;
  logic [LEN:0]     mul_sum, div_shift;
  logic             div_ge;
  logic [LEN-1:0]   div_rem;
  logic [2*LEN-1:0] p_step, prod;
  logic [LEN-1:0]   quo, rem;

  // Decode the start request and compute one multiply or divide iteration.
  always_comb begin
    signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
    div_op    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    a_neg     = signed_op && i_a[LEN-1];
    b_neg     = signed_op && i_b[LEN-1];
    a_mag     = a_neg ? -i_a : i_a;
    b_mag     = b_neg ? -i_b : i_b;

    mul_sum   = {1'b0, p_q[2*LEN-1:LEN]} + (p_q[0] ? {1'b0, b_q} : '0);
    div_shift = {p_q[2*LEN-1:LEN], p_q[LEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_rem   = div_ge ? (div_shift[LEN-1:0] - b_q) : div_shift[LEN-1:0];
    p_step    = is_div_q ? {div_rem, p_q[LEN-2:0], div_ge} : {mul_sum, p_q[LEN-1:1]};

    cnt_d      = cnt_q;
    p_d        = p_q;
    b_d        = b_q;
    a_d        = a_q;
    is_div_d   = is_div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    b_zero_d   = b_zero_q;
    if (i_abort) begin
      cnt_d = '0;
    end else if (i_start) begin
      cnt_d      = CW'(LEN);
      p_d        = {{LEN{1'b0}}, a_mag};
      b_d        = b_mag;
      a_d        = i_a;
      is_div_d   = div_op;
      neg_main_d = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      b_zero_d   = (i_b == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      p_d   = p_step;
    end
  end

  // Post-correct the final iteration; a zero divisor bypasses the datapath.
  always_comb begin
    o_done = (cnt_q == CW'(1));
    prod   = neg_main_q ? -p_step : p_step;
    quo    = neg_main_q ? -p_step[LEN-1:0] : p_step[LEN-1:0];
    rem    = neg_rem_q ? -p_step[2*LEN-1:LEN] : p_step[2*LEN-1:LEN];
    o_hi   = prod[2*LEN-1:LEN];
    o_lo   = prod[LEN-1:0];
    if (is_div_q) begin
      if (b_zero_q) begin
        o_hi = a_q;
        o_lo = '1;
      end else begin
        o_hi = rem;
        o_lo = quo;
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= '0;
      p_q        <= '0;
      b_q        <= '0;
      a_q        <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      b_q        <= b_d;
      a_q        <= a_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      b_zero_q   <= b_zero_d;
    end
  end

endmodule

// File: rtl/seg_execute_md.sv
// Execute stage with operand forwarding, a stalling multiply/divide unit,
// architectural HI/LO and the EX/MEM output register.
module seg_execute_md
  import seg_execute_pkg::*;
#(
  parameter int LEN     = 32,
  parameter int NB_ADDR = 5,
  parameter int N_FWD   = 2,
  localparam int NB_SEL = nb_sel(N_FWD)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_flush,
  input  logic [2:0]         i_md_op,
  input  logic [LEN-1:0]     i_read_data_1,
  input  logic [LEN-1:0]     i_read_data_2,
  input  logic [N_FWD*LEN-1:0] i_fwd_data,
  input  logic [NB_SEL-1:0]  i_sel_a,
  input  logic [NB_SEL-1:0]  i_sel_b,
  input  logic [LEN-1:0]     i_alu_result,
  input  logic [NB_ADDR-1:0] i_write_register,
  input  logic               i_reg_write,
  output logic               o_stall,
  output logic               o_valid,
  output logic [LEN-1:0]     o_result,
  output logic [NB_ADDR-1:0] o_write_register,
  output logic               o_reg_write,
  output logic [LEN-1:0]     o_hi,
  output logic [LEN-1:0]     o_lo
);

  md_state_e          state_q, state_d;
  logic [LEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic               valid_q, valid_d, rw_q, rw_d;
  logic [LEN-1:0]     result_q, result_d;
  logic [NB_ADDR-1:0] wr_q, wr_d;
  logic [LEN-1:0]     op_a, op_b;
  logic               start, core_done;
  logic [LEN-1:0]     core_hi, core_lo;

  // Forwarding muxes; out-of-range selects fall back to the register file.
  always_comb begin
    op_a = i_read_data_1;
    op_b = i_read_data_2;
    for (int k = 1; k <= N_FWD; k++) begin
      if (i_sel_a == NB_SEL'(k)) op_a = i_fwd_data[(k-1)*LEN +: LEN];
      if (i_sel_b == NB_SEL'(k)) op_b = i_fwd_data[(k-1)*LEN +: LEN];
    end
  end

  seg_execute_md_core #(.LEN(LEN)) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start),
    .i_abort (i_flush),
    .i_op    (i_md_op),
    .i_a     (op_a),
    .i_b     (op_b),
    .o_done  (core_done),
    .o_hi    (core_hi),
    .o_lo    (core_lo)
  );

  // Control FSM and HI/LO commit; a flush always wins and never commits.
  always_comb begin
    start   = (state_q == ST_IDLE) && i_valid && is_md_op(i_md_op) && !i_flush;
    o_stall = start || (state_q == ST_BUSY);
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        if (core_done) begin
          state_d = ST_DONE;
          hi_d    = core_hi;
          lo_d    = core_lo;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // Output register: bubble while stalled, otherwise retire the instruction.
  always_comb begin
    valid_d  = 1'b0;
    rw_d     = 1'b0;
    result_d = result_q;
    wr_d     = wr_q;
    if (!o_stall) begin
      valid_d = i_valid && !i_flush;
      case (i_md_op)
        OP_MFHI: result_d = hi_q;
        OP_MFLO: result_d = lo_q;
        default: result_d = i_alu_result;
      endcase
      wr_d = i_write_register;
      rw_d = i_reg_write && valid_d && !is_md_op(i_md_op);
    end
  end

  // State, HI/LO and EX/MEM registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      rw_q     <= 1'b0;
      result_q <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      rw_q     <= rw_d;
      result_q <= result_d;
      wr_q     <= wr_d;
    end
  end

  assign o_valid          = valid_q;
  assign o_result         = result_q;
  assign o_write_register = wr_q;
  assign o_reg_write      = rw_q;
  assign o_hi             = hi_q;
  assign o_lo             = lo_q;

endmodule

// File: doc/seg_execute_md.md
SEG_EXECUTE_MD -- requirements
Module: seg_execute_md

Interface
REQ-001 Parameter LEN, default 32: datapath width, even, >=8.
REQ-002 Parameter NB_ADDR, default 5: register-address width.
REQ-003 Parameter N_FWD, default 2: number of forwarding sources; NB_SEL = clog2(N_FWD+1).
REQ-004 Port i_clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port i_rst  in  1: synchronous, active-high reset.
REQ-006 Port i_valid  in  1: an instruction is presented this cycle.
REQ-007 Port i_flush  in  1: squash the current instruction and abort any divide or multiply in progress.
REQ-008 Port i_md_op  in  3: 000 ALU, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 reserved (treated as ALU).
REQ-009 Ports i_read_data_1, i_read_data_2  in  LEN: register-file operands.
REQ-010 Port i_fwd_data  in  N_FWD*LEN: forwarding values; slice k-1 is source k.
REQ-011 Ports i_sel_a, i_sel_b  in  NB_SEL: forwarding selects for operands A and B.
REQ-012 Ports i_alu_result  in  LEN, i_write_register  in  NB_ADDR, i_reg_write  in  1: same-cycle ALU result and write-back control.
REQ-013 Port o_stall  out  1: upstream holds the instruction and this block accepts nothing.
REQ-014 Ports o_valid 1, o_result LEN, o_write_register NB_ADDR, o_reg_write 1  out: registered EX/MEM outputs.
REQ-015 Ports o_hi, o_lo  out  LEN: architectural HI and LO registers.

Function
REQ-016 Operand select: sel 0 picks i_read_data_n; sel k (1..N_FWD) picks forwarding slice k-1; sel > N_FWD picks i_read_data_n.
REQ-017 The control FSM has three states: IDLE, BUSY and DONE.
REQ-018 IDLE: a cycle with i_valid, an op of 001-100 and no i_flush latches both selected operands, loads the counter with LEN and moves to BUSY.
REQ-019 BUSY: one iteration runs per cycle and the counter decrements. When the counter reaches 1, HI and LO are written and the FSM moves to DONE.
REQ-020 DONE: the FSM moves to IDLE unconditionally. The held instruction retires this cycle and is not restarted.
REQ-021 o_stall is combinational and equals (IDLE & i_valid & op in 001-100 & !i_flush) | BUSY, so it is high for exactly LEN+1 consecutive cycles per multiply or divide.
REQ-022 MULT and MULTU produce a 2*LEN-bit product: HI takes the upper half and LO the lower half. MULT is signed; MULTU is unsigned.
REQ-023 DIV and DIVU write the quotient to LO and the remainder to HI. Signed quotients truncate toward zero, and the remainder takes the sign of the dividend.
REQ-024 DIV with operands MIN and -1 gives LO=MIN and HI=0.
REQ-025 A divisor of zero gives HI=dividend and LO=all ones, with no exception.
REQ-026 The output register updates every cycle in which o_stall=0:
- o_valid = i_valid & !i_flush.
- o_result = HI for MFHI, LO for MFLO, otherwise i_alu_result.
- o_reg_write = i_reg_write & o_valid, forced to 0 for ops 001-100.
REQ-027 While o_stall=1, the output register loads a bubble: o_valid=0, o_reg_write=0, o_result and o_write_register unchanged.
REQ-028 An MFHI or MFLO presented in the cycle after DONE reads the newly written HI or LO; HI and LO need no separate bypass.
REQ-029 i_flush in any state forces IDLE next cycle, loads a bubble into the output register and leaves HI and LO unchanged; a partial result is never committed.
REQ-030 i_flush has priority over a simultaneous multiply or divide start.

Reset
REQ-031 While i_rst=1 the block SHALL force, on the next edge: state IDLE, counter 0, HI=LO=0, o_valid=0, o_reg_write=0, o_result=0, o_write_register=0.
REQ-032 Reset mid-BUSY SHALL abandon the operation with no HI/LO update; o_stall SHALL read 0 in the cycle after reset.

Structure
REQ-033 The op encodings, FSM state encodings and the NB_SEL function SHALL live in the shared package seg_execute_pkg.
REQ-034 The iterative shift-add multiplier and restoring divider, with sign pre- and post-correction, SHALL be the sub-module seg_execute_md_core. It takes start, op and operands and returns done, hi and lo.
REQ-035 Forwarding muxes, the FSM and the output register SHALL stay in the top level.

Verification
REQ-036 MULT A=0xFFFFFFFF, B=2 SHALL give o_stall high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE and o_reg_write=0 at retire.
REQ-037 MULTU with the same operands SHALL give HI=0x00000001, LO=0xFFFFFFFE; a following MFLO SHALL give o_result=0xFFFFFFFE.
REQ-038 DIV -7/2 SHALL give LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 SHALL give HI=5, LO=0xFFFFFFFF.
REQ-039 With sel_a=1, sel_b=2, fwd0=3 and fwd1=4, MULTU SHALL give LO=12; with sel_a=3 the operand SHALL be i_read_data_1.
REQ-040 i_flush on the 10th BUSY cycle SHALL give IDLE next cycle, o_stall=0 and HI/LO unchanged.
REQ-041 i_rst mid-BUSY SHALL give HI=LO=0, IDLE and o_stall=0.
